// File: rtl/si5340_i2c_target_pkg.sv
// Shared constants, state encodings and pointer helper for the Si5340 I2C target model.
// SI5340_TARGET_AUTOINC_EN selects whether the register pointer advances after each data byte.
package si5340_i2c_target_pkg;

    localparam int DATA_WIDTH     = 8;
    localparam int REG_ADDR_WIDTH = 16;

    // Device address shared with the config loader.
    localparam logic [6:0] SLAVE_ADDR_DEF = 7'h74;

    typedef logic [2:0] tgt_state_t;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DEV_ADDR = 3'd1;
    localparam logic [2:0] ST_REG_HI   = 3'd2;
    localparam logic [2:0] ST_REG_LO   = 3'd3;
    localparam logic [2:0] ST_WR_DATA  = 3'd4;
    localparam logic [2:0] ST_RD_DATA  = 3'd5;
    localparam logic [2:0] ST_RD_ACK   = 3'd6;
    localparam logic [2:0] ST_IGNORE   = 3'd7;

    function automatic logic [REG_ADDR_WIDTH-1:0] ptr_advance(input logic [REG_ADDR_WIDTH-1:0] p);
`ifdef SI5340_TARGET_AUTOINC_EN
        return p + 16'd1;
`else
        return p;
`endif
    endfunction

endpackage

// File: rtl/si5340_i2c_target_bus_cond.sv
// Pad synchronizer + FILT_LEN stability filter; emits SCL edge and START/STOP strobes.
// Strobes appear 2 + FILT_LEN clk_i cycles after a pad edge; no backpressure.
module si5340_i2c_target_bus_cond #(
    parameter int FILT_LEN = 4
) (
    input  logic clk_i,
    input  logic arstn_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_det_o,
    output logic stop_det_o,
    output logic sda_o
);

    localparam int CW = $clog2(FILT_LEN + 1);

    logic [1:0]    scl_sync_q, sda_sync_q;
    logic          scl_filt_q, scl_filt_d, sda_filt_q, sda_filt_d;
    logic          scl_prev_q, sda_prev_q;
    logic [CW-1:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;

    // A filtered level flips only after FILT_LEN consecutive samples disagree with it.
    always_comb begin
        scl_filt_d = scl_filt_q;
        scl_cnt_d  = '0;
        if (scl_sync_q[1] != scl_filt_q) begin
            if (scl_cnt_q == CW'(FILT_LEN - 1)) scl_filt_d = scl_sync_q[1];
            else                                scl_cnt_d  = scl_cnt_q + CW'(1);
        end
        sda_filt_d = sda_filt_q;
        sda_cnt_d  = '0;
        if (sda_sync_q[1] != sda_filt_q) begin
            if (sda_cnt_q == CW'(FILT_LEN - 1)) sda_filt_d = sda_sync_q[1];
            else                                sda_cnt_d  = sda_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            scl_cnt_q  <= '0;
            sda_cnt_q  <= '0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_filt_q <= scl_filt_d;
            sda_filt_q <= sda_filt_d;
            scl_prev_q <= scl_filt_q;
            sda_prev_q <= sda_filt_q;
            scl_cnt_q  <= scl_cnt_d;
            sda_cnt_q  <= sda_cnt_d;
        end
    end

    assign scl_rise_o  =  scl_filt_q & ~scl_prev_q;
    assign scl_fall_o  = ~scl_filt_q &  scl_prev_q;
    assign start_det_o =  scl_filt_q &  scl_prev_q &  sda_prev_q & ~sda_filt_q;
    assign stop_det_o  =  scl_filt_q &  scl_prev_q & ~sda_prev_q &  sda_filt_q;
    assign sda_o       =  sda_filt_q;

endmodule

// File: rtl/si5340_i2c_target.sv
// Si5340-style I2C target: 7-bit address, 16-bit register pointer, byte reads/writes to a local array.
// wr_valid_o fires one cycle after the filtered 8th SCL rise; SCL is never stretched. SI5340_TARGET_AUTOINC_EN enables pointer auto-increment.
module si5340_i2c_target
    import si5340_i2c_target_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = SLAVE_ADDR_DEF,
    parameter int         REG_DEPTH  = 256,
    parameter int         FILT_LEN   = 4
) (
    input  logic                      clk_i,
    input  logic                      arstn_i,
    input  logic                      scl_pad_i,
    input  logic                      sda_pad_i,
    output logic                      sda_pad_o,
    output logic                      sda_padoen_o,
    output logic                      wr_valid_o,
    output logic [REG_ADDR_WIDTH-1:0] wr_addr_o,
    output logic [DATA_WIDTH-1:0]     wr_data_o,
    output logic                      busy_o
);

    localparam int AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
    localparam logic [REG_ADDR_WIDTH:0] DEPTH_LIM = (REG_ADDR_WIDTH + 1)'(REG_DEPTH);

    logic scl_rise, scl_fall, start_det, stop_det, sda_f;

    si5340_i2c_target_bus_cond #(.FILT_LEN(FILT_LEN)) u_i2c_bus_cond (
        .clk_i       (clk_i),
        .arstn_i     (arstn_i),
        .scl_i       (scl_pad_i),
        .sda_i       (sda_pad_i),
        .scl_rise_o  (scl_rise),
        .scl_fall_o  (scl_fall),
        .start_det_o (start_det),
        .stop_det_o  (stop_det),
        .sda_o       (sda_f)
    );

    tgt_state_t                state_q, state_d;
    logic [2:0]                bit_cnt_q, bit_cnt_d;
    logic                      ack_phase_q, ack_phase_d;
    logic                      ack_drv_q, ack_drv_d;
    logic [DATA_WIDTH-1:0]     shift_q, shift_d;
    logic [REG_ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                      sda_oen_q, sda_oen_d;
    logic                      wr_valid_q, wr_valid_d;
    logic [REG_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]     wr_data_q, wr_data_d;
    logic                      busy_q, busy_d;

    logic [DATA_WIDTH-1:0]     mem_q [REG_DEPTH];
    logic                      mem_we;
    logic [DATA_WIDTH-1:0]     rx_byte;
    logic [REG_ADDR_WIDTH-1:0] ptr_adv;
    logic                      ptr_in_range, adv_in_range;
    logic [DATA_WIDTH-1:0]     rd_now, rd_adv;

    assign ptr_adv      = ptr_advance(ptr_q);
    assign ptr_in_range = ({1'b0, ptr_q}   < DEPTH_LIM);
    assign adv_in_range = ({1'b0, ptr_adv} < DEPTH_LIM);
    assign rd_now       = ptr_in_range ? mem_q[ptr_q[AW-1:0]]   : 8'hFF;
    assign rd_adv       = adv_in_range ? mem_q[ptr_adv[AW-1:0]] : 8'hFF;
    assign rx_byte      = {shift_q[6:0], sda_f};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        ack_phase_d = ack_phase_q;
        ack_drv_d   = ack_drv_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        sda_oen_d   = sda_oen_q;
        wr_valid_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        busy_d      = busy_q;
        mem_we      = 1'b0;

        if (stop_det) begin
            state_d     = ST_IDLE;
            bit_cnt_d   = 3'd0;
            ack_phase_d = 1'b0;
            ack_drv_d   = 1'b0;
            sda_oen_d   = 1'b1;
            busy_d      = 1'b0;
        end else if (start_det) begin
            state_d     = ST_DEV_ADDR;
            bit_cnt_d   = 3'd0;
            ack_phase_d = 1'b0;
            ack_drv_d   = 1'b0;
            sda_oen_d   = 1'b1;
        end else if (ack_phase_q) begin
            // First fall drives ACK; second fall ends the 9th clock and, on reads, presents bit 7.
            if (scl_fall) begin
                if (!ack_drv_q) begin
                    sda_oen_d = 1'b0;
                    ack_drv_d = 1'b1;
                end else begin
                    ack_phase_d = 1'b0;
                    ack_drv_d   = 1'b0;
                    sda_oen_d   = (state_q == ST_RD_DATA) ? shift_q[7] : 1'b1;
                end
            end
        end else if (state_q == ST_DEV_ADDR || state_q == ST_REG_HI ||
                     state_q == ST_REG_LO   || state_q == ST_WR_DATA) begin
            if (scl_rise) begin
                shift_d   = rx_byte;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    ack_phase_d = 1'b1;
                    if (state_q == ST_DEV_ADDR) begin
                        if (rx_byte[7:1] == SLAVE_ADDR) begin
                            busy_d = 1'b1;
                            if (rx_byte[0]) begin
                                shift_d = rd_now;
                                state_d = ST_RD_DATA;
                            end else begin
                                state_d = ST_REG_HI;
                            end
                        end else begin
                            ack_phase_d = 1'b0;
                            state_d     = ST_IGNORE;
                        end
                    end else if (state_q == ST_REG_HI) begin
                        ptr_d[15:8] = rx_byte;
                        state_d     = ST_REG_LO;
                    end else if (state_q == ST_REG_LO) begin
                        ptr_d[7:0] = rx_byte;
                        state_d    = ST_WR_DATA;
                    end else begin
                        // Out-of-range writes are still ACKed and reported, just not stored.
                        wr_valid_d = 1'b1;
                        wr_addr_d  = ptr_q;
                        wr_data_d  = rx_byte;
                        mem_we     = ptr_in_range;
                        ptr_d      = ptr_adv;
                    end
                end
            end
        end else if (state_q == ST_RD_DATA) begin
            if (scl_fall) begin
                sda_oen_d = shift_q[7];
            end else if (scl_rise) begin
                shift_d   = {shift_q[6:0], 1'b1};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) state_d = ST_RD_ACK;
            end
        end else if (state_q == ST_RD_ACK) begin
            if (scl_fall) begin
                sda_oen_d = 1'b1;
            end else if (scl_rise) begin
                if (!sda_f) begin
                    ptr_d   = ptr_adv;
                    shift_d = rd_adv;
                    state_d = ST_RD_DATA;
                end else begin
                    state_d = ST_IGNORE;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            ack_phase_q <= 1'b0;
            ack_drv_q   <= 1'b0;
            shift_q     <= '0;
            ptr_q       <= '0;
            sda_oen_q   <= 1'b1;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            ack_phase_q <= ack_phase_d;
            ack_drv_q   <= ack_drv_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            sda_oen_q   <= sda_oen_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= busy_d;
        end
    end

    // Register contents survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem_q[ptr_q[AW-1:0]] <= rx_byte;
    end

    assign sda_pad_o    = 1'b0;
    assign sda_padoen_o = sda_oen_q;
    assign wr_valid_o   = wr_valid_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign busy_o       = busy_q;

endmodule
